// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID/EX hazard controller.
//   RegW       register-number width
//   hz_state_t controller state (RUN, MC_WAIT)
//   fwd_sel_t  operand source select (regfile, EX result, MEM result)
package hazard_pkg;

  localparam int unsigned RegW = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: single source/producer RAW comparator.
//   rs_i    source register number of the consumer in ID
//   used_i  consumer actually reads rs_i
//   rd_i    producer destination register
//   we_i    producer writes rd_i
//   match_o consumer depends on producer (x0 never matches)
module hazard_match
  import hazard_pkg::*;
(
  input  logic [RegW-1:0] rs_i,
  input  logic            used_i,
  input  logic [RegW-1:0] rd_i,
  input  logic            we_i,
  output logic            match_o
);

  assign match_o = we_i && used_i && (rs_i != '0) && (rs_i == rd_i);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX hazard controller for the 5-stage core.
// Detects RAW hazards against EX/MEM producers, drives operand forwarding
// selects, PC / IF/ID / ID/EX hold, flush and bubble controls, and sequences
// multi-cycle EX stalls with a sticky watchdog.
//
// Configuration macro: HAZARD_FWD_EN
//   defined   - forwarding enabled, data stalls only on load-use
//   undefined - fwd_a/fwd_b tied to 0, any EX/MEM match stalls
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1n/id_rs2n          ID source registers, with *_used qualifiers
//   ex_rdn/ex_reg_write      EX producer, ex_is_load marks a load
//   mem_rdn/mem_reg_write    MEM producer
//   br_mispredict            branch in EX resolved against fetch direction
//   ex_mc_valid, mc_done     multi-cycle op in EX, result-ready pulse
//   pc_hold, ifid_hold       freeze PC / IF/ID
//   ifid_flush               load NOP into IF/ID
//   idex_hold, idex_bubble   freeze ID/EX / load NOP into ID/EX
//   fwd_a, fwd_b             operand source (0 RF, 1 EX, 2 MEM)
//   mc_timeout               sticky watchdog flag
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned McTimeout = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RegW-1:0] id_rs1n,
  input  logic [RegW-1:0] id_rs2n,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RegW-1:0] ex_rdn,
  input  logic            ex_reg_write,
  input  logic            ex_is_load,
  input  logic [RegW-1:0] mem_rdn,
  input  logic            mem_reg_write,
  input  logic            br_mispredict,
  input  logic            ex_mc_valid,
  input  logic            mc_done,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_hold,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mc_timeout
);

  localparam int unsigned CntW    = $clog2(McTimeout + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(McTimeout);
  localparam logic [CntW-1:0] CntLast = CntW'(McTimeout - 1);

  hz_state_t       state_q;
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  logic m1_ex, m2_ex, m1_mem, m2_mem;
  logic data_stall;
  logic mc_stall;

  hazard_match u_m1_ex (
    .rs_i(id_rs1n), .used_i(id_rs1_used), .rd_i(ex_rdn), .we_i(ex_reg_write), .match_o(m1_ex)
  );
  hazard_match u_m2_ex (
    .rs_i(id_rs2n), .used_i(id_rs2_used), .rd_i(ex_rdn), .we_i(ex_reg_write), .match_o(m2_ex)
  );
  hazard_match u_m1_mem (
    .rs_i(id_rs1n), .used_i(id_rs1_used), .rd_i(mem_rdn), .we_i(mem_reg_write), .match_o(m1_mem)
  );
  hazard_match u_m2_mem (
    .rs_i(id_rs2n), .used_i(id_rs2_used), .rd_i(mem_rdn), .we_i(mem_reg_write), .match_o(m2_mem)
  );

`ifdef HAZARD_FWD_EN
  // A load's data is not available in EX, so it falls through to the MEM
  // select; the accompanying load-use stall covers the gap.
  assign data_stall = ex_is_load && (m1_ex || m2_ex);
  assign fwd_a = (m1_ex && !ex_is_load) ? FWD_EX : (m1_mem ? FWD_MEM : FWD_RF);
  assign fwd_b = (m2_ex && !ex_is_load) ? FWD_EX : (m2_mem ? FWD_MEM : FWD_RF);
`else
  // No bypass network: wait until the producer reaches WB (write-through).
  assign data_stall = m1_ex || m2_ex || m1_mem || m2_mem;
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign mc_stall   = ex_mc_valid && !mc_done;
  assign mc_timeout = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          cnt_q <= '0;
          if (!br_mispredict && mc_stall) begin
            state_q <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            // Saturate at the limit; the flag is sticky until reset.
            if (cnt_q != CntMax) begin
              cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == CntLast) begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (br_mispredict) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (mc_stall) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
        end else if (data_stall) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      MC_WAIT: begin
        if (!mc_done) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          idex_hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
